// File: rtl/bias_stream_pkg.sv
// Shared types and default sizing for the bias streamer and its store.
package bias_stream_pkg;

    localparam int DEFAULT_DEPTH = 64;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bias_regfile.sv
// Bias word store: DEPTH x WIDTH, one synchronous write port,
// one combinational read port, whole array cleared by reset.
module bias_regfile
    import bias_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             bias_rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: unchanged except for the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Array register; reset wipes every entry so a fresh block streams zeros.
    always_ff @(posedge clk or posedge bias_rst) begin
        if (bias_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bias_streamer.sv
// Streams one block of DEPTH bias words to a receiver on request.
// A block is: one buf_clr pulse, DEPTH bias_en strobes (stretched by
// hold), then a one-cycle done pulse. Host writes are only accepted
// while idle; writes arriving mid-block are dropped and flagged.
module bias_streamer
    import bias_stream_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int REVERSE = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             bias_rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             hold,
    output logic             buf_clr,
    output logic             bias_en,
    output logic [WIDTH-1:0] bias_out,
    output logic             busy,
    output logic             done,
    output logic             wr_drop
);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             buf_clr_q, buf_clr_d;
    logic             bias_en_q, bias_en_d;
    logic [WIDTH-1:0] bias_out_q, bias_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_drop_q, wr_drop_d;

    logic             store_we;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    assign store_we = wr_en && (state_q == ST_IDLE);

    // Word counter maps to a store address, mirrored when streaming top-down.
    always_comb begin
        if (REVERSE != 0) begin
            rd_addr = AW'(DEPTH - 1) - cnt_q[AW-1:0];
        end else begin
            rd_addr = cnt_q[AW-1:0];
        end
    end

    bias_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_store (
        .clk      (clk),
        .bias_rst (bias_rst),
        .wr_en    (store_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Next state and next registered outputs; bias_out is zeroed on the way into IDLE/CLEAR.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_clr_d  = 1'b0;
        bias_en_d  = 1'b0;
        bias_out_d = bias_out_q;
        done_d     = 1'b0;
        wr_drop_d  = wr_en && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                bias_out_d = '0;
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                buf_clr_d  = 1'b1;
                cnt_d      = '0;
                bias_out_d = '0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (!hold) begin
                    bias_en_d  = 1'b1;
                    bias_out_d = rd_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                bias_out_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge bias_rst) begin
        if (bias_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            buf_clr_q  <= 1'b0;
            bias_en_q  <= 1'b0;
            bias_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_clr_q  <= buf_clr_d;
            bias_en_q  <= bias_en_d;
            bias_out_q <= bias_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    assign buf_clr  = buf_clr_q;
    assign bias_en  = bias_en_q;
    assign bias_out = bias_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_bias_streamer.sv
// Bench for bias_streamer: a forward and a reversed instance share all
// inputs and are checked against a block-level model of the bias store.
module tb_bias_streamer;

    localparam int DEPTH = 64;
    localparam int WIDTH = 16;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             bias_rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             hold;

    logic             buf_clr_o  [2];
    logic             bias_en_o  [2];
    logic [WIDTH-1:0] bias_out_o [2];
    logic             busy_o     [2];
    logic             done_o     [2];
    logic             wr_drop_o  [2];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    bias_streamer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REVERSE(0)) dut_fwd (
        .clk(clk), .bias_rst(bias_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .hold(hold),
        .buf_clr(buf_clr_o[0]), .bias_en(bias_en_o[0]), .bias_out(bias_out_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .wr_drop(wr_drop_o[0])
    );

    bias_streamer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REVERSE(1)) dut_rev (
        .clk(clk), .bias_rst(bias_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .hold(hold),
        .buf_clr(buf_clr_o[1]), .bias_en(bias_en_o[1]), .bias_out(bias_out_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .wr_drop(wr_drop_o[1])
    );

    // One comparison: counts it, and reports tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every output of both instances must be quiet.
    task automatic checkIdle(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s dut%0d buf_clr", tag, d),  32'(buf_clr_o[d]),  32'd0);
            checkOutput($sformatf("%s dut%0d bias_en", tag, d),  32'(bias_en_o[d]),  32'd0);
            checkOutput($sformatf("%s dut%0d bias_out", tag, d), 32'(bias_out_o[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d busy", tag, d),     32'(busy_o[d]),     32'd0);
            checkOutput($sformatf("%s dut%0d done", tag, d),     32'(done_o[d]),     32'd0);
            checkOutput($sformatf("%s dut%0d wr_drop", tag, d),  32'(wr_drop_o[d]),  32'd0);
        end
    endtask

    // Host write while idle: must land in the store and never be flagged as dropped.
    task automatic applyWrite(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        model_mem[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("write dut%0d wr_drop", d), 32'(wr_drop_o[d]), 32'd0);
            checkOutput($sformatf("write dut%0d busy", d),    32'(busy_o[d]),    32'd0);
        end
    endtask

    // One block from start to done. Observation c is taken c edges after the
    // start edge: buf_clr at c=1, a word each non-held STREAM cycle from c=2,
    // done at c = DEPTH+2 plus one per hold that landed while words remained.
    task automatic applyStimulus(input int hold_pct, input bit script_hold,
                                 input bit drop_test, input bit restart_test,
                                 input int abort_word, input bit ws_en,
                                 input logic [AW-1:0] ws_addr,
                                 input logic [WIDTH-1:0] ws_data);
        logic [WIDTH-1:0] blk [DEPTH];
        logic [WIDTH-1:0] last [2];
        logic [WIDTH-1:0] w [2];
        logic [WIDTH-1:0] exp_out;
        int  k, stalls, hold_left;
        bit  hold_prev, wr_prev, en_now, done_now, script_used, aborted;
        k = 0; stalls = 0; hold_left = 0;
        hold_prev = 1'b0; wr_prev = 1'b0; script_used = 1'b0; aborted = 1'b0;
        last[0] = '0; last[1] = '0;
        w[0] = '0; w[1] = '0;

        start = 1'b1;
        hold  = 1'b0;
        if (ws_en) begin
            wr_en   = 1'b1;
            wr_addr = ws_addr;
            wr_data = ws_data;
            model_mem[ws_addr] = ws_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            blk[i] = model_mem[i];
        end

        for (int c = 0; c < 1000 && !aborted; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            en_now   = (c >= 2) && !hold_prev && (k < DEPTH);
            done_now = (c == DEPTH + 2 + stalls);
            if (en_now) begin
                w[0] = blk[k];
                w[1] = blk[DEPTH - 1 - k];
            end
            for (int d = 0; d < 2; d++) begin
                exp_out = en_now ? w[d] : (done_now ? '0 : last[d]);
                checkOutput($sformatf("c%0d dut%0d buf_clr", c, d),  32'(buf_clr_o[d]),  32'(c == 1));
                checkOutput($sformatf("c%0d dut%0d bias_en", c, d),  32'(bias_en_o[d]),  32'(en_now));
                checkOutput($sformatf("c%0d dut%0d bias_out", c, d), 32'(bias_out_o[d]), 32'(exp_out));
                checkOutput($sformatf("c%0d dut%0d done", c, d),     32'(done_o[d]),     32'(done_now));
                checkOutput($sformatf("c%0d dut%0d busy", c, d),     32'(busy_o[d]),     32'(!done_now));
                checkOutput($sformatf("c%0d dut%0d wr_drop", c, d),  32'(wr_drop_o[d]),  32'(wr_prev));
                if (en_now) begin
                    last[d] = w[d];
                end
            end
            if (en_now) begin
                k++;
            end
            if (done_now) begin
                break;
            end

            if (abort_word >= 0 && k == abort_word + 1) begin
                #2 bias_rst = 1'b1;
                #1 checkIdle("abort_async");
                for (int i = 0; i < DEPTH; i++) begin
                    model_mem[i] = '0;
                end
                hold = 1'b0;
                @(negedge clk);
                checkIdle("abort_held");
                bias_rst = 1'b0;
                @(negedge clk);
                checkIdle("abort_release");
                aborted = 1'b1;
            end else begin
                wr_prev = 1'b0;
                if (drop_test && c == 30) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(5);
                    wr_data = 16'hFFFF;
                    wr_prev = 1'b1;
                end
                if (restart_test && c == 40) begin
                    start = 1'b1;
                end
                if (hold_left > 0) begin
                    hold = 1'b1;
                    hold_left--;
                end else if (script_hold && !script_used && k == 11) begin
                    script_used = 1'b1;
                    hold        = 1'b1;
                    hold_left   = 2;
                end else begin
                    hold = (c < 300) && ($urandom_range(99) < 32'(hold_pct));
                end
                if (hold && c >= 1 && k < DEPTH) begin
                    stalls++;
                end
                hold_prev = hold;
            end
        end

        hold = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            checkIdle("post_block");
        end
    endtask

    initial begin
        int nw;
        bias_rst = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        hold     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
        end

        @(negedge clk);
        checkIdle("in_reset");
        @(negedge clk);
        bias_rst = 1'b0;
        @(negedge clk);
        checkIdle("after_reset");

        $display("[TB] loading ramp image 0x0100+i");
        for (int i = 0; i < DEPTH; i++) begin
            applyWrite(AW'(i), WIDTH'(16'h0100 + i));
        end

        $display("[TB] plain block, forward and reversed");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0, '0);

        $display("[TB] three-cycle hold after word 10");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, -1, 1'b0, '0, '0);

        $display("[TB] write and restart while streaming");
        applyStimulus(0, 1'b0, 1'b1, 1'b1, -1, 1'b0, '0, '0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0, '0);

        $display("[TB] reset at word 20, then a block of zeros");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 20, 1'b0, '0, '0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0, '0);

        $display("[TB] write to address 0 together with start");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, -1, 1'b1, AW'(0), 16'h7FFF);

        $display("[TB] randomized writes and hold");
        for (int b = 0; b < 4; b++) begin
            nw = int'($urandom_range(1, 12));
            for (int j = 0; j < nw; j++) begin
                applyWrite(AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
            end
            applyStimulus(30, 1'b0, 1'b0, 1'b0, -1, 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
